// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for the 5-stage pipeline. Keeps its own EX/MEM/WB scoreboard of
//   destination register and Tnew, compares it against the ID source registers
//   and their Tuse, and produces stall / EX-bubble and forwarding selects for
//   the ID and EX operands. Also tracks the multi-cycle mult/div unit so that
//   HI/LO users wait until the MDU is idle.
//
//   Optional feature: define HAZARD_PERF_EN to add the 32-bit stall_cnt output
//   (number of stalled cycles since reset, wrapping). Without the macro the
//   port and its counter do not exist.

module hazard_scoreboard #(
  parameter int AW       = 5,   // register address width
  parameter int TW       = 2,   // Tnew / Tuse width
  parameter int MULT_CYC = 5,   // mult busy cycles after start
  parameter int DIV_CYC  = 10,  // div busy cycles after start
  parameter int CW       = 4    // MDU counter width, holds max(MULT_CYC, DIV_CYC)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [TW-1:0] id_tuse_rs,
  input  logic [TW-1:0] id_tuse_rt,
  input  logic [AW-1:0] id_wa,
  input  logic          id_we,
  input  logic [TW-1:0] id_tnew,
  input  logic          id_md_use,
  input  logic          md_start,
  input  logic          md_div,
  output logic          stall,
  output logic          ex_bubble,
  output logic          md_busy,
  output logic [1:0]    fwd_id_rs,
  output logic [1:0]    fwd_id_rt,
  output logic [1:0]    fwd_ex_rs,
`ifdef HAZARD_PERF_EN
  output logic [1:0]    fwd_ex_rt,
  output logic [31:0]   stall_cnt
`else
  output logic [1:0]    fwd_ex_rt
`endif
);

  // One scoreboard slot: destination register (0 = not live) and cycles until
  // its result can be forwarded.
  typedef struct packed {
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
  } sb_entry_t;

  // Forward-select encoding shared by the ID and EX operand muxes.
  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC);

  // Tnew count-down, saturating at zero so oversize decodes settle cleanly.
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // A source is hazardous when its youngest in-flight producer is still too
  // far from producing compared to when ID needs the value. Older matches are
  // shadowed by the younger write and must be ignored.
  function automatic logic src_hazard(input logic [AW-1:0] r,
                                      input logic [TW-1:0] u,
                                      input sb_entry_t     ex,
                                      input sb_entry_t     mem,
                                      input sb_entry_t     wb);
    logic hz;
    hz = 1'b0;
    if (r != '0) begin
      if (ex.wa == r)       hz = (ex.tnew  > u);
      else if (mem.wa == r) hz = (mem.tnew > u);
      else if (wb.wa == r)  hz = (wb.tnew  > u);
    end
    return hz;
  endfunction

  // ID operand select: take the youngest producer of r, but only once its
  // value exists; otherwise read the register file (stall or EX forwarding
  // will cover the late value).
  function automatic logic [1:0] id_fwd_sel(input logic [AW-1:0] r,
                                            input sb_entry_t     ex,
                                            input sb_entry_t     mem,
                                            input sb_entry_t     wb);
    logic [1:0] sel;
    sel = SEL_REG;
    if (r != '0) begin
      if (ex.wa == r)       sel = (ex.tnew  == '0) ? SEL_EX  : SEL_REG;
      else if (mem.wa == r) sel = (mem.tnew == '0) ? SEL_MEM : SEL_REG;
      else if (wb.wa == r)  sel = (wb.tnew  == '0) ? SEL_WB  : SEL_REG;
    end
    return sel;
  endfunction

  // EX operand select: same rule, looking only at the stages behind EX.
  function automatic logic [1:0] ex_fwd_sel(input logic [AW-1:0] r,
                                            input sb_entry_t     mem,
                                            input sb_entry_t     wb);
    logic [1:0] sel;
    sel = SEL_REG;
    if (r != '0) begin
      if (mem.wa == r)     sel = (mem.tnew == '0) ? SEL_MEM : SEL_REG;
      else if (wb.wa == r) sel = (wb.tnew  == '0) ? SEL_WB  : SEL_REG;
    end
    return sel;
  endfunction

  sb_entry_t       ex_q,  ex_d;
  sb_entry_t       mem_q, mem_d;
  sb_entry_t       wb_q,  wb_d;
  logic [AW-1:0]   ex_rs_q, ex_rs_d;
  logic [AW-1:0]   ex_rt_q, ex_rt_d;
  logic [CW-1:0]   md_cnt_q, md_cnt_d;

  logic            hazard_rs;
  logic            hazard_rt;
  logic            mdstall;
  logic            stall_int;

  // Hazard detection and stall generation for the instruction sitting in ID.
  always_comb begin
    hazard_rs = src_hazard(id_rs, id_tuse_rs, ex_q, mem_q, wb_q);
    hazard_rt = src_hazard(id_rt, id_tuse_rt, ex_q, mem_q, wb_q);
    mdstall   = id_valid & id_md_use & (md_busy | md_start);
    // NOTE: reset_n gates the combinational stall so that it drops in the
    // same cycle reset asserts, even if an MDU start is presented meanwhile.
    stall_int = reset_n & id_valid & (hazard_rs | hazard_rt | mdstall);
  end

  assign stall     = stall_int;
  assign ex_bubble = stall_int;
  assign md_busy   = (md_cnt_q != '0);

  // Forwarding selects for both pipeline points.
  always_comb begin
    fwd_id_rs = id_fwd_sel(id_rs, ex_q, mem_q, wb_q);
    fwd_id_rt = id_fwd_sel(id_rt, ex_q, mem_q, wb_q);
    fwd_ex_rs = ex_fwd_sel(ex_rs_q, mem_q, wb_q);
    fwd_ex_rt = ex_fwd_sel(ex_rt_q, mem_q, wb_q);
  end

  // Scoreboard shift: ID enters EX unless stalled or empty, older stages age.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    ex_d    = '0;
    ex_rs_d = '0;
    ex_rt_d = '0;
    if (!stall_int && id_valid) begin
      ex_d.wa   = id_we ? id_wa : '0;
      ex_d.tnew = id_we ? id_tnew : '0;
      ex_rs_d   = id_rs;
      ex_rt_d   = id_rt;
    end
    mem_d.wa   = ex_q.wa;
    mem_d.tnew = dec_sat(ex_q.tnew);
    wb_d.wa    = mem_q.wa;
    wb_d.tnew  = dec_sat(mem_q.tnew);
  end

  // MDU busy counter: start loads the op latency, otherwise count down to idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start)              md_cnt_d = md_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - CW'(1);
  end

  // State registers, cleared asynchronously to an empty pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rs_q  <= '0;
      ex_rt_q  <= '0;
      md_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, giving a true one-stage shift.
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      ex_rs_q  <= ex_rs_d;
      ex_rt_q  <= ex_rt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Performance counter of stalled cycles, wrapping naturally at 2**32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       stall_cnt_q <= '0;
    else if (stall_int) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed pipeline scenarios followed by randomized traffic. Each cycle the
//   stimulus process predicts the outputs from a reference model and pushes
//   them into a queue; a monitor on the falling edge pops and compares.
//   The model keeps the last three instructions that entered EX with their
//   original Tnew and derives the remaining latency from their age; the MDU
//   model remembers the cycle of the last start and its latency.

module tb_hazard_scoreboard;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wa = '0;
  logic [1:0] id_tuse_rs = 2'd3, id_tuse_rt = 2'd3, id_tnew = '0;
  logic       id_we = 1'b0, id_md_use = 1'b0, md_start = 1'b0, md_div = 1'b0;
  logic       stall, ex_bubble, md_busy;
  logic [1:0] fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard #(
    .AW(5), .TW(2), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CW(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs),
    .id_tuse_rt(id_tuse_rt),
    .id_wa(id_wa),
    .id_we(id_we),
    .id_tnew(id_tnew),
    .id_md_use(id_md_use),
    .md_start(md_start),
    .md_div(md_div),
    .stall(stall),
    .ex_bubble(ex_bubble),
    .md_busy(md_busy),
    .fwd_id_rs(fwd_id_rs),
    .fwd_id_rt(fwd_id_rt),
    .fwd_ex_rs(fwd_ex_rs),
    .fwd_ex_rt(fwd_ex_rt)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs, rt, wa;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic       we, md_use, md_start, md_div;
  } stim_t;

  typedef struct {
    logic       stall;
    logic       md_busy;
    logic [1:0] fi_rs, fi_rt, fe_rs, fe_rt;
  } exp_t;

  typedef struct {
    int wa;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  exp_t exp_q[$];
  ent_t hist[$];        // hist[k]: instruction that entered EX k cycles ago
  int   cyc = 0;
  int   md_start_cyc = -1000;
  int   md_len = 0;
  int   model_stalls = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rst = 1'b0; s.valid = 1'b0; s.rs = '0; s.rt = '0; s.wa = '0;
    s.tuse_rs = 2'd3; s.tuse_rt = 2'd3; s.tnew = '0;
    s.we = 1'b0; s.md_use = 1'b0; s.md_start = 1'b0; s.md_div = 1'b0;
    return s;
  endfunction

  function automatic ent_t bubble();
    ent_t e;
    e.wa = 0; e.tnew = 0; e.rs = 0; e.rt = 0;
    return e;
  endfunction

  // Cycles still needed by the producer that entered EX k cycles ago.
  function automatic int remaining(int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  function automatic bit m_hazard(int r, int u);
    if (r == 0) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (hist[k].wa == r) return remaining(k) > u;
    return 1'b0;
  endfunction

  // Forward from stage index first..2 (0=EX,1=MEM,2=WB); select = index+1.
  function automatic int m_fwd(int r, int first);
    if (r == 0) return 0;
    for (int k = first; k < 3; k++)
      if (hist[k].wa == r) return (remaining(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  // Predict, drive, then advance the model by one clock.
  task automatic step(input stim_t s);
    exp_t e;
    ent_t n;
    bit   busy, hz;
    if (s.rst) begin
      hist = '{bubble(), bubble(), bubble()};
      md_start_cyc = -1000;
    end
    busy = !s.rst && (cyc - md_start_cyc >= 1) && (cyc - md_start_cyc <= md_len);
    hz = m_hazard(int'(s.rs), int'(s.tuse_rs)) || m_hazard(int'(s.rt), int'(s.tuse_rt)) ||
         (s.md_use && (busy || s.md_start));
    e.stall   = !s.rst && s.valid && hz;
    e.md_busy = busy;
    e.fi_rs   = 2'(m_fwd(int'(s.rs), 0));
    e.fi_rt   = 2'(m_fwd(int'(s.rt), 0));
    e.fe_rs   = 2'(m_fwd(hist[0].rs, 1));
    e.fe_rt   = 2'(m_fwd(hist[0].rt, 1));
    exp_q.push_back(e);

    reset_n    = !s.rst;
    id_valid   = s.valid;
    id_rs      = s.rs;
    id_rt      = s.rt;
    id_tuse_rs = s.tuse_rs;
    id_tuse_rt = s.tuse_rt;
    id_wa      = s.wa;
    id_we      = s.we;
    id_tnew    = s.tnew;
    id_md_use  = s.md_use;
    md_start   = s.md_start;
    md_div     = s.md_div;

    n = bubble();
    if (!s.rst && s.valid && !e.stall) begin
      n.wa   = s.we ? int'(s.wa) : 0;
      n.tnew = int'(s.tnew);
      n.rs   = int'(s.rs);
      n.rt   = int'(s.rt);
    end
    hist.push_front(n);
    void'(hist.pop_back());
    if (s.rst) model_stalls = 0;
    else if (e.stall) model_stalls++;
    if (!s.rst && s.md_start) begin
      md_start_cyc = cyc;
      md_len = s.md_div ? DIV_CYC : MULT_CYC;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: outputs are combinational, settled by the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stall",     stall,     e.stall);
      check("ex_bubble", ex_bubble, e.stall);
      check("md_busy",   md_busy,   e.md_busy);
      check("fwd_id_rs", fwd_id_rs, e.fi_rs);
      check("fwd_id_rt", fwd_id_rt, e.fi_rt);
      check("fwd_ex_rs", fwd_ex_rs, e.fe_rs);
      check("fwd_ex_rt", fwd_ex_rt, e.fe_rt);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    hist = '{bubble(), bubble(), bubble()};
    @(posedge clk);
    #1;

    // Reset state, with an MDU start and HI/LO user held during reset.
    s = nop(); s.rst = 1'b1; s.valid = 1'b1; s.md_use = 1'b1; s.md_start = 1'b1;
    s.rs = 5'd1; step(s);
    s = nop(); s.rst = 1'b1; step(s);

    // lw $1 (tnew 2) followed by beq $1 (tuse 0).
    s = nop(); s.valid = 1'b1; s.wa = 5'd1; s.we = 1'b1; s.tnew = 2'd2; step(s);
    s = nop(); s.valid = 1'b1; s.rs = 5'd1; s.tuse_rs = 2'd0; repeat (3) step(s);
    repeat (3) step(nop());

    // addu $3 (tnew 1) then addu $4,$3 (tuse 1), back to back and with a gap.
    s = nop(); s.valid = 1'b1; s.wa = 5'd3; s.we = 1'b1; s.tnew = 2'd1; step(s);
    s = nop(); s.valid = 1'b1; s.rs = 5'd3; s.tuse_rs = 2'd1; s.wa = 5'd4; s.we = 1'b1;
    s.tnew = 2'd1; step(s);
    repeat (3) step(nop());
    s = nop(); s.valid = 1'b1; s.wa = 5'd3; s.we = 1'b1; s.tnew = 2'd1; step(s);
    step(nop());
    s = nop(); s.valid = 1'b1; s.rt = 5'd3; s.tuse_rt = 2'd1; step(s);
    repeat (3) step(nop());

    // Writes to $0 in every stage, then a read of $0.
    s = nop(); s.valid = 1'b1; s.wa = 5'd0; s.we = 1'b1; s.tnew = 2'd2; repeat (3) step(s);
    s = nop(); s.valid = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.tuse_rs = 2'd0; s.tuse_rt = 2'd0;
    step(s);
    repeat (3) step(nop());

    // div start with mfhi waiting in ID each cycle.
    s = nop(); s.valid = 1'b1; s.md_use = 1'b1; s.md_start = 1'b1; s.md_div = 1'b1; step(s);
    s = nop(); s.valid = 1'b1; s.md_use = 1'b1; repeat (12) step(s);

    // Reset in the middle of a div, then mfhi issues unstalled.
    s = nop(); s.md_start = 1'b1; s.md_div = 1'b1; step(s);
    repeat (4) step(nop());
    s = nop(); s.rst = 1'b1; s.valid = 1'b1; s.md_use = 1'b1; step(s);
    s = nop(); s.valid = 1'b1; s.md_use = 1'b1; repeat (2) step(s);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      s = nop();
      s.rst      = ($urandom_range(0, 79) == 0);
      s.valid    = ($urandom_range(0, 7) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.wa       = 5'($urandom_range(0, 3));
      s.we       = ($urandom_range(0, 3) != 0);
      s.tnew     = 2'($urandom_range(0, 2));
      s.md_use   = ($urandom_range(0, 5) == 0);
      s.md_start = ($urandom_range(0, 11) == 0);
      s.md_div   = $urandom_range(0, 1);
      step(s);
    end

    check("scoreboard_drained", exp_q.size(), 0);
`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt, model_stalls);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
